// File: rtl/operand_fetch.sv
`timescale 1ns/1ps
// Issue stage between decode and execute: reads the register file, stalls load-use
// dependents and holds the ID/EX register under backpressure while snooping writeback.
module operand_fetch #(
    parameter int DATA_W         = 32,
    parameter int REG_ID_W       = 5,
    parameter int LOAD_USE_STALL = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [REG_ID_W-1:0] in_rs,
    input  logic [REG_ID_W-1:0] in_rt,
    input  logic [REG_ID_W-1:0] in_rd,
    input  logic [DATA_W-1:0]   in_imm,
    input  logic                in_reg_write,
    input  logic                in_mem_read,
    output logic [REG_ID_W-1:0] rf_read1,
    output logic [REG_ID_W-1:0] rf_read2,
    input  logic [DATA_W-1:0]   rf_read1_data,
    input  logic [DATA_W-1:0]   rf_read2_data,
    input  logic                wb_en,
    input  logic [REG_ID_W-1:0] wb_id,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_pc,
    output logic [DATA_W-1:0]   out_imm,
    output logic [DATA_W-1:0]   out_a,
    output logic [DATA_W-1:0]   out_b,
    output logic [REG_ID_W-1:0] out_rd,
    output logic                out_reg_write,
    output logic                out_mem_read
);

    localparam int CNT_W = 3;

    logic [CNT_W-1:0]    cnt;
    logic [REG_ID_W-1:0] ld_rd;
    logic [REG_ID_W-1:0] held_rs;
    logic [REG_ID_W-1:0] held_rt;
    logic                hazard;
    logic                accept;
    logic                fire;
    logic                load_fire;

    function automatic logic dep(input logic [REG_ID_W-1:0] r,
                                 input logic [REG_ID_W-1:0] rs,
                                 input logic [REG_ID_W-1:0] rt);
        return (r != '0) && ((r == rs) || (r == rt));
    endfunction

    assign rf_read1 = in_rs;
    assign rf_read2 = in_rt;

    always_comb begin
        hazard = (out_valid && out_mem_read && dep(out_rd, in_rs, in_rt)) ||
                 ((cnt != '0) && dep(ld_rd, in_rs, in_rt));
    end

    assign in_ready  = rst_n && !flush && !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign load_fire = fire && out_mem_read && (out_rd != '0);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_imm       <= '0;
            out_a         <= '0;
            out_b         <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            held_rs       <= '0;
            held_rt       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_imm       <= in_imm;
            out_a         <= (in_rs == '0) ? '0 : rf_read1_data;
            out_b         <= (in_rt == '0) ? '0 : rf_read2_data;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
            out_mem_read  <= in_mem_read;
            held_rs       <= in_rs;
            held_rt       <= in_rt;
        end else if (fire) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            // Stalled downstream: refresh operands the writeback port is updating.
            if (wb_en && (wb_id != '0) && (wb_id == held_rs)) out_a <= wb_data;
            if (wb_en && (wb_id != '0) && (wb_id == held_rt)) out_b <= wb_data;
        end
    end

    // Only the most recent load is tracked; a newer load's window always covers the older one's end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ld_rd <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (load_fire) begin
            cnt   <= CNT_W'(LOAD_USE_STALL);
            ld_rd <= out_rd;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
`timescale 1ns/1ps
// Self-checking bench for operand_fetch: directed scenarios followed by random traffic,
// compared against a cycle-numbered reference model of the issue rules.
module tb_operand_fetch;

    localparam int DATA_W = 32;
    localparam int REG_ID_W = 5;
    localparam int LUS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        in_reg_write;
    logic        in_mem_read;
    logic [4:0]  rf_read1;
    logic [4:0]  rf_read2;
    logic [31:0] rf_read1_data;
    logic [31:0] rf_read2_data;
    logic        wb_en;
    logic [4:0]  wb_id;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .LOAD_USE_STALL(LUS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_read1_data(rf_read1_data), .rf_read2_data(rf_read2_data),
        .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
    );

    // Register file with same-cycle write bypass; override lets a test force the read data.
    logic [31:0] regs [32];
    logic        rf_override;
    logic [31:0] override_val;

    always @(posedge clk) if (wb_en && wb_id != 5'd0) regs[wb_id] <= wb_data;

    assign rf_read1_data = rf_override ? override_val :
                           (wb_en && wb_id == rf_read1 && rf_read1 != 5'd0) ? wb_data : regs[rf_read1];
    assign rf_read2_data = rf_override ? override_val :
                           (wb_en && wb_id == rf_read2 && rf_read2 != 5'd0) ? wb_data : regs[rf_read2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the ID/EX contents plus the cycle number of the last tracked load.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rw;
        logic        mr;
    } model_t;

    model_t     m;
    int         cyc = 0;
    int         last_load_cyc = -100;
    logic [4:0] last_load_rd = 5'd0;
    logic       seen_ready;

    function automatic logic reads(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt);
        return (r != 5'd0) && (r == rs || r == rt);
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (rf_override) return override_val;
        if (wb_en && wb_id == r) return wb_data;
        return regs[r];
    endfunction

    function automatic logic model_ready();
        logic blocked;
        int   age;
        age = cyc - last_load_cyc;
        blocked = (m.valid && m.mr && reads(m.rd, in_rs, in_rt)) ||
                  (age >= 1 && age <= LUS && reads(last_load_rd, in_rs, in_rt));
        return rst_n && !flush && !blocked && (!m.valid || out_ready);
    endfunction

    task automatic model_reset();
        m = '0;
        last_load_cyc = -100;
    endtask

    task automatic tick();
        model_t n;
        logic   exp_ready;
        logic   acc;
        logic   fire;
        @(negedge clk);
        exp_ready = model_ready();
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("rf_read_addr", {22'd0, rf_read2, rf_read1}, {22'd0, in_rt, in_rs});
        seen_ready = in_ready;
        acc  = in_valid && exp_ready;
        fire = m.valid && out_ready;
        n = m;
        if (!rst_n) begin
            n = '0;
            last_load_cyc = -100;
        end else if (flush) begin
            n.valid = 1'b0;
            last_load_cyc = -100;
        end else begin
            if (fire && m.mr && m.rd != 5'd0) begin
                last_load_cyc = cyc;
                last_load_rd  = m.rd;
            end
            if (acc) begin
                n.valid = 1'b1;
                n.pc = in_pc;  n.imm = in_imm;
                n.a  = src_val(in_rs);
                n.b  = src_val(in_rt);
                n.rd = in_rd;  n.rs = in_rs;  n.rt = in_rt;
                n.rw = in_reg_write;  n.mr = in_mem_read;
            end else if (fire) begin
                n.valid = 1'b0;
            end else if (m.valid) begin
                if (wb_en && wb_id != 5'd0 && wb_id == m.rs) n.a = wb_data;
                if (wb_en && wb_id != 5'd0 && wb_id == m.rt) n.b = wb_data;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        m = n;
        check("out_valid", {31'd0, out_valid}, {31'd0, m.valid});
        if (m.valid) begin
            check("out_pc", out_pc, m.pc);
            check("out_imm", out_imm, m.imm);
            check("out_a", out_a, m.a);
            check("out_b", out_b, m.b);
            check("out_ctl", {25'd0, out_rd, out_reg_write, out_mem_read}, {25'd0, m.rd, m.rw, m.mr});
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic mr);
        in_valid = v;  in_rs = rs;  in_rt = rt;  in_rd = rd;
        in_mem_read = mr;  in_reg_write = 1'b1;
        in_pc = $urandom;  in_imm = $urandom;
    endtask

    initial begin
        logic [31:0] b_keep;
        rst_n = 1'b0;  flush = 1'b0;  out_ready = 1'b0;
        wb_en = 1'b0;  wb_id = 5'd0;  wb_data = 32'd0;
        rf_override = 1'b0;  override_val = 32'd0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        model_reset();
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_payload", out_pc | out_imm | out_a | out_b, 32'd0);
        check("rst_ctl", {25'd0, out_rd, out_reg_write, out_mem_read}, 32'd0);

        // Fill the register file through the writeback port while held in reset.
        for (int r = 1; r < 16; r++) begin
            wb_en = 1'b1;  wb_id = 5'(r);
            wb_data = (r == 7) ? 32'h11 : $urandom;
            tick();
        end
        wb_en = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Streaming independent ALU ops.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd1, 5'd2, 5'(3 + k), 1'b0);
            tick();
            check("stream_ready", {31'd0, seen_ready}, 32'd1);
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Load-use stall: load r5 fires at T, consumer held T..T+2, accepted at T+3.
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b0);
        tick();
        check("lu_T0", {31'd0, seen_ready}, 32'd0);
        tick();
        check("lu_T1", {31'd0, seen_ready}, 32'd0);
        tick();
        check("lu_T2", {31'd0, seen_ready}, 32'd0);
        wb_en = 1'b1;  wb_id = 5'd5;  wb_data = 32'hCAFE_0005;
        tick();
        check("lu_T3", {31'd0, seen_ready}, 32'd1);
        check("lu_bypass", out_a, 32'hCAFE_0005);
        wb_en = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        drive(1'b1, 5'd6, 5'd2, 5'd8, 1'b0);
        tick();
        check("lu_indep", {31'd0, seen_ready}, 32'd1);

        // rd=0 load and r0 source never stall; r0 reads as zero.
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd3, 5'd4, 1'b0);
        rf_override = 1'b1;  override_val = 32'hDEAD_BEEF;
        tick();
        check("r0_ready", {31'd0, seen_ready}, 32'd1);
        check("r0_zero", out_a, 32'd0);
        check("r0_other", out_b, 32'hDEAD_BEEF);
        rf_override = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Backpressure snoop.
        out_ready = 1'b0;
        b_keep = regs[2];
        drive(1'b1, 5'd7, 5'd2, 5'd3, 1'b0);
        tick();
        check("snoop_capture", out_a, 32'h11);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb_en = 1'b1;  wb_id = 5'd7;  wb_data = 32'h22;
        tick();
        check("snoop_a", out_a, 32'h22);
        check("snoop_b", out_b, b_keep);
        wb_en = 1'b0;
        out_ready = 1'b1;
        tick();
        check("snoop_fire", {31'd0, out_valid}, 32'd0);
        check("snoop_kept", out_a, 32'h22);
        tick();

        // Flush alongside a load fire discards its tracking.
        drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        drive(1'b1, 5'd9, 5'd0, 5'd4, 1'b0);
        tick();
        check("flush_ready", {31'd0, seen_ready}, 32'd1);
        check("flush_accept", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Async reset while the stall counter is loaded.
        drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1);
        tick();
        drive(1'b1, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_payload", out_pc | out_imm | out_a | out_b, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 5'd10, 5'd0, 5'd4, 1'b0);
        tick();
        check("arst_dep_ready", {31'd0, seen_ready}, 32'd1);
        check("arst_dep_valid", {31'd0, out_valid}, 32'd1);

        // Random traffic over a small register window to provoke dependencies.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 9) < 3);
            in_reg_write = 1'($urandom);
            out_ready    = $urandom_range(0, 9) < 7;
            flush        = $urandom_range(0, 24) == 0;
            wb_en        = $urandom_range(0, 9) < 3;
            wb_id        = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            rf_override  = $urandom_range(0, 19) == 0;
            override_val = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage between decode and execute in the 32-entry integer pipeline.
- Drives the register file read addresses and captures the read data with the decoded instruction into the ID/EX pipeline register.
- Detects load-use hazards and stalls upstream; the register file's same-cycle write bypass covers writeback.
- While the held instruction is stalled downstream, snoops the writeback port so held operands never go stale.

Parameters:
DATA_W, 32, operand/immediate/PC width (op_t)
REG_ID_W, 5, register index width (reg_id_t)
LOAD_USE_STALL, 2, cycles a dependent is held after its producing load leaves this stage (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  DATA_W  instruction PC
in_rs  in  REG_ID_W  source A index
in_rt  in  REG_ID_W  source B index
in_rd  in  REG_ID_W  destination index
in_imm  in  DATA_W  sign-extended immediate
in_reg_write  in  1  instruction writes rd
in_mem_read  in  1  instruction is a load
rf_read1  out  REG_ID_W  register file read address 1 (= in_rs)
rf_read2  out  REG_ID_W  register file read address 2 (= in_rt)
rf_read1_data  in  DATA_W  register file read data 1
rf_read2_data  in  DATA_W  register file read data 2
wb_en  in  1  writeback enable (same signals that drive the register file)
wb_id  in  REG_ID_W  writeback index
wb_data  in  DATA_W  writeback data
flush  in  1  kill held instruction and pending hazard state
out_valid  out  1  ID/EX register valid
out_ready  in  1  execute accepts
out_pc, out_imm, out_a, out_b  out  DATA_W  registered payload/operands
out_rd  out  REG_ID_W  registered destination
out_reg_write, out_mem_read  out  1  registered control

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; all out_* payload=0.
  - Stall counter cnt=0; ld_rd=0.
  - in_ready=0 while rst_n=0.
- rf_read1/rf_read2 are combinational copies of in_rs/in_rt.
- Dependency: dep(r) = r!=0 && (r==in_rs || r==in_rt). Dependencies are checked regardless of in_reg_write of the consumer.
- hazard = (out_valid && out_mem_read && dep(out_rd)) || (cnt!=0 && dep(ld_rd)).
- in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready). Purely combinational; in_valid must not be required for in_ready.
- Accept (in_valid && in_ready), on the next edge:
  - out_valid=1; payload latched.
  - out_a = (in_rs==0) ? 0 : rf_read1_data; out_b likewise with in_rt. Forced to 0 for index 0 regardless of the register file.
  - Latency: one cycle, decode to out_valid.
- Downstream fire (out_valid && out_ready) with no accept: out_valid=0 next cycle; payload unchanged.
- Hold (out_valid && !out_ready):
  - All payload held.
  - Exception: if wb_en && wb_id!=0 && wb_id==held rs (resp. rt), out_a (resp. out_b) takes wb_data at the edge.
  - Held rs/rt are stored internally for this purpose.
- Load tracking:
  - When a fire occurs with out_mem_read=1 and out_rd!=0: cnt<=LOAD_USE_STALL, ld_rd<=out_rd. This overrides any decrement that cycle.
  - Otherwise cnt decrements by 1 while nonzero and saturates at 0.
  - Result: a load firing in cycle T blocks a dependent at T (through the out-register term) and at T+1..T+LOAD_USE_STALL. The dependent is accepted no earlier than T+LOAD_USE_STALL+1.
  - Independent instructions flow with no bubble.
- Back-to-back loads: each fire reloads cnt/ld_rd. Only the most recent load is tracked; this is sufficient because the older load's window is no longer than the newer one's.
- Flush (synchronous, highest priority):
  - Next edge: out_valid=0, cnt=0. No accept that cycle, since in_ready=0.
  - A concurrent fire is still honoured by downstream, but its load tracking is discarded.
- Simultaneous fire and accept: the new instruction replaces the old one in the same edge (full throughput).
- Reset asserted mid-stall: all state cleared immediately; no pending hazard survives.

Test Plan:
- Streaming: 4 independent ALU ops (rs=1,rt=2,rd=3..6), out_ready=1 held high -> out_valid high 4 consecutive cycles starting 1 cycle after first accept; out_a/out_b equal register contents; in_ready never drops.
- Load-use: load rd=5 fires at cycle T, next instruction rs=5, LOAD_USE_STALL=2 -> in_ready=0 at T, T+1, T+2; accepted at T+3; out_a equals wb_data written for r5 (via register file bypass). Repeat with rs=6 -> no stall.
- rd=0 load and r0 source: load rd=0 then consumer rs=0 -> no stall; out_a=0 even if rf_read1_data drives 0xDEADBEEF.
- Backpressure snoop: hold out_ready=0 with instruction rs=7 captured (out_a=0x11); pulse wb_en, wb_id=7, wb_data=0x22 -> out_a=0x22 next cycle; out_b unchanged; release out_ready -> fires once.
- Flush: load rd=9 fires and flush=1 in the same cycle; next cycle consumer rs=9 -> out_valid=0 after flush; consumer accepted immediately (cnt=0).
- Async reset mid-hazard: assert rst_n=0 between clock edges while cnt=2 -> out_valid=0 and payload=0 immediately; after release, dependent accepted on first cycle.
